// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out stage feeding a SIPO shift register.
//
// A WIDTH-bit word is accepted through a valid/ready handshake and driven out
// on Sout one bit per Clock. The first bit appears in the cycle after the
// accept edge. Frames can run back-to-back with no idle gap.
//
// Optional feature macro: PISO_PARITY_EN
//   defined   : each frame carries one trailing even-parity bit (WIDTH+1 bits)
//   undefined : frame is exactly WIDTH bits, no parity logic
//
// Parameters:
//   WIDTH      word width in bits (2..32)
//   LSB_FIRST  0 = MSB shifted first, 1 = LSB shifted first
//   IDLE_LEVEL level driven on Sout when no frame is active
//
// Ports:
//   Clock       system clock, rising edge
//   Clear       asynchronous active-high reset
//   Pin         parallel word, sampled on the accept edge
//   Load_Valid  Pin holds a word to send
//   Load_Ready  combinational: block can accept a word this cycle
//   Sout        registered serial data
//   Sout_Valid  Sout carries a frame bit this cycle
//   Frame_Done  high while the last bit of a frame is on Sout
//   Frame_Count completed frames, wraps 255 -> 0
module piso_serializer #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Pin,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  output logic             Sout,
  output logic             Sout_Valid,
  output logic             Frame_Done,
  output logic [7:0]       Frame_Count
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_BITS = WIDTH + 1;
`else
  localparam int unsigned FRAME_BITS = WIDTH;
`endif
  localparam int unsigned CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sout_q, sout_d;
  logic                  sout_valid_q, sout_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [7:0]            frame_count_q, frame_count_d;

  logic [FRAME_BITS-1:0] frame_w;
  logic                  last_bit;
  logic                  accept;

  // Frame image in shift order: head bit is shifted out first.
  always_comb begin
`ifdef PISO_PARITY_EN
    if (LSB_FIRST) begin
      frame_w = {^Pin, Pin};
    end else begin
      frame_w = {Pin, ^Pin};
    end
`else
    frame_w = Pin;
`endif
  end

  // Bit at the output end of the shift register.
  function automatic logic head_of(input logic [FRAME_BITS-1:0] v);
    return LSB_FIRST ? v[0] : v[FRAME_BITS-1];
  endfunction

  // Shift register after removing the head bit.
  function automatic logic [FRAME_BITS-1:0] drop_head(input logic [FRAME_BITS-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  // cnt_q counts the frame bits still to follow the one currently on Sout.
  assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign Load_Ready = !Clear && ((state_q == ST_IDLE) || last_bit);
  assign accept     = Load_Valid && Load_Ready;

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    sout_d        = IDLE_LEVEL;
    sout_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    if (last_bit) begin
      frame_count_d = frame_count_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_SHIFT;
          sout_d       = head_of(frame_w);
          sout_valid_d = 1'b1;
          shreg_d      = drop_head(frame_w);
          cnt_d        = CNT_W'(FRAME_BITS - 1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          sout_d       = head_of(shreg_q);
          sout_valid_d = 1'b1;
          frame_done_d = (cnt_q == CNT_W'(1));
          shreg_d      = drop_head(shreg_q);
          cnt_d        = cnt_q - CNT_W'(1);
        end else if (accept) begin
          // Reload on the last bit so the next frame follows with no gap.
          sout_d       = head_of(frame_w);
          sout_valid_d = 1'b1;
          shreg_d      = drop_head(frame_w);
          cnt_d        = CNT_W'(FRAME_BITS - 1);
        end else begin
          state_d = ST_IDLE;
          shreg_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      sout_q        <= IDLE_LEVEL;
      sout_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign Sout        = sout_q;
  assign Sout_Valid  = sout_valid_q;
  assign Frame_Done  = frame_done_q;
  assign Frame_Count = frame_count_q;

  // Frame_Done only ever marks a valid frame bit.
  a_done_is_valid: assert property (@(posedge Clock) disable iff (Clear)
    Frame_Done |-> Sout_Valid);

  // An idle block keeps the line quiet.
  a_idle_quiet: assert property (@(posedge Clock) disable iff (Clear)
    (state_q == ST_IDLE) |-> (!Sout_Valid && (Sout == IDLE_LEVEL)));

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus randomized
// traffic against a queue-based bit-stream model.
module tb_piso_serializer;

  localparam int unsigned W    = 4;
  localparam bit          LSB  = 1'b0;
  localparam bit          IDLE = 1'b0;
`ifdef PISO_PARITY_EN
  localparam int unsigned FB = W + 1;
`else
  localparam int unsigned FB = W;
`endif
  localparam int FBI = int'(FB);

  logic         Clock;
  logic         Clear;
  logic [W-1:0] Pin;
  logic         Load_Valid;
  logic         Load_Ready;
  logic         Sout;
  logic         Sout_Valid;
  logic         Frame_Done;
  logic [7:0]   Frame_Count;

  logic [W-1:0] sipo;
  logic [7:0]   exp_count;
  int           n_vec;
  int           n_err;

  piso_serializer #(
    .WIDTH      (W),
    .LSB_FIRST  (LSB),
    .IDLE_LEVEL (IDLE)
  ) dut (
    .Clock       (Clock),
    .Clear       (Clear),
    .Pin         (Pin),
    .Load_Valid  (Load_Valid),
    .Load_Ready  (Load_Ready),
    .Sout        (Sout),
    .Sout_Valid  (Sout_Valid),
    .Frame_Done  (Frame_Done),
    .Frame_Count (Frame_Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Downstream SIPO: fills from the LSB end, first bit ends up at the MSB.
  always @(posedge Clock) begin
    if (Sout_Valid) sipo <= {sipo[W-2:0], Sout};
  end

  // Serial bit sequence of one frame; index 0 goes on the line first.
  function automatic logic [FB-1:0] frame_of(input logic [W-1:0] w);
    logic [FB-1:0] f;
    f = '0;
    for (int i = 0; i < int'(W); i++) begin
      f[i] = LSB ? w[i] : w[int'(W) - 1 - i];
    end
`ifdef PISO_PARITY_EN
    f[W] = ^w;
`endif
    return f;
  endfunction

  task automatic test_reset();
    Clear = 1'b1; Load_Valid = 1'b0; Pin = '0;
    repeat (2) @(negedge Clock);
    n_vec++; if (Sout !== IDLE) begin n_err++; $display("FAIL reset_sout: got %b want %b", Sout, IDLE); end
    n_vec++; if (Sout_Valid !== 1'b0) begin n_err++; $display("FAIL reset_sout_valid: got %b want 0", Sout_Valid); end
    n_vec++; if (Frame_Done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", Frame_Done); end
    n_vec++; if (Frame_Count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", Frame_Count); end
    n_vec++; if (Load_Ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_clear: got %b want 0", Load_Ready); end
    Clear = 1'b0;
    #1;
    n_vec++; if (Load_Ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b want 1", Load_Ready); end
    exp_count = '0;
  endtask

  // Sends one word starting now (low clock phase) and checks the whole frame.
  task automatic test_single_frame(input logic [W-1:0] w, input string tag);
    logic [FB-1:0] f;
    f = frame_of(w);
    Pin = w; Load_Valid = 1'b1;
    #1;
    n_vec++; if (Load_Ready !== 1'b1) begin n_err++; $display("FAIL %s_ready: got %b want 1", tag, Load_Ready); end
    @(negedge Clock);
    Load_Valid = 1'b0; Pin = W'($urandom);
    for (int k = 0; k < FBI; k++) begin
      n_vec++; if (Sout !== f[k]) begin n_err++; $display("FAIL %s_bit%0d: Sout=%b want %b", tag, k, Sout, f[k]); end
      n_vec++; if (Sout_Valid !== 1'b1) begin n_err++; $display("FAIL %s_valid%0d: got %b want 1", tag, k, Sout_Valid); end
      n_vec++; if (Frame_Done !== (k == FBI - 1)) begin n_err++; $display("FAIL %s_done%0d: got %b want %b", tag, k, Frame_Done, (k == FBI - 1)); end
      n_vec++; if (Load_Ready !== (k == FBI - 1)) begin n_err++; $display("FAIL %s_lready%0d: got %b want %b", tag, k, Load_Ready, (k == FBI - 1)); end
      @(negedge Clock);
    end
    exp_count = exp_count + 8'd1;
    n_vec++; if (Sout !== IDLE) begin n_err++; $display("FAIL %s_idle_sout: got %b want %b", tag, Sout, IDLE); end
    n_vec++; if (Sout_Valid !== 1'b0) begin n_err++; $display("FAIL %s_idle_valid: got %b want 0", tag, Sout_Valid); end
    n_vec++; if (Frame_Done !== 1'b0) begin n_err++; $display("FAIL %s_idle_done: got %b want 0", tag, Frame_Done); end
    n_vec++; if (Frame_Count !== exp_count) begin n_err++; $display("FAIL %s_count: got %0d want %0d", tag, Frame_Count, exp_count); end
  endtask

  task automatic test_back_to_back(input logic [W-1:0] w0, input logic [W-1:0] w1);
    logic [2*FB-1:0] s;
    logic            edge_bit;
    s = {frame_of(w1), frame_of(w0)};
    Pin = w0; Load_Valid = 1'b1;
    @(negedge Clock);
    Pin = w1;
    for (int k = 0; k < 2 * FBI; k++) begin
      if (k == FBI) Load_Valid = 1'b0;
      edge_bit = (k == FBI - 1) || (k == 2 * FBI - 1);
      n_vec++; if (Sout !== s[k]) begin n_err++; $display("FAIL b2b_bit%0d: Sout=%b want %b", k, Sout, s[k]); end
      n_vec++; if (Sout_Valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d: got %b want 1", k, Sout_Valid); end
      n_vec++; if (Frame_Done !== edge_bit) begin n_err++; $display("FAIL b2b_done%0d: got %b want %b", k, Frame_Done, edge_bit); end
      n_vec++; if (Load_Ready !== edge_bit) begin n_err++; $display("FAIL b2b_lready%0d: got %b want %b", k, Load_Ready, edge_bit); end
      @(negedge Clock);
    end
    exp_count = exp_count + 8'd2;
    n_vec++; if (Sout_Valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_valid: got %b want 0", Sout_Valid); end
    n_vec++; if (Frame_Count !== exp_count) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", Frame_Count, exp_count); end
  endtask

  task automatic test_sipo(input logic [W-1:0] w);
    logic [W-1:0] want;
    for (int i = 0; i < int'(W); i++) want[i] = LSB ? w[int'(W) - 1 - i] : w[i];
    Pin = w; Load_Valid = 1'b1;
    @(negedge Clock);
    Load_Valid = 1'b0;
    repeat (W) @(negedge Clock);
    n_vec++; if (sipo !== want) begin n_err++; $display("FAIL sipo_pout: got %b want %b", sipo, want); end
    repeat (FB - W) @(negedge Clock);
    exp_count = exp_count + 8'd1;
    n_vec++; if (Sout_Valid !== 1'b0) begin n_err++; $display("FAIL sipo_idle_valid: got %b want 0", Sout_Valid); end
    n_vec++; if (Frame_Count !== exp_count) begin n_err++; $display("FAIL sipo_count: got %0d want %0d", Frame_Count, exp_count); end
  endtask

  task automatic test_ignore_busy(input logic [W-1:0] w, input logic [W-1:0] junk);
    logic [FB-1:0] f;
    int            p;
    f = frame_of(w);
    p = (FBI > 2) ? 1 : 0;
    Pin = w; Load_Valid = 1'b1;
    @(negedge Clock);
    Load_Valid = 1'b0;
    for (int k = 0; k < FBI; k++) begin
      if (k == p) begin Pin = junk; Load_Valid = 1'b1; end
      else if (k == p + 1) Load_Valid = 1'b0;
      n_vec++; if (Sout !== f[k]) begin n_err++; $display("FAIL busy_bit%0d: Sout=%b want %b", k, Sout, f[k]); end
      n_vec++; if (Frame_Done !== (k == FBI - 1)) begin n_err++; $display("FAIL busy_done%0d: got %b want %b", k, Frame_Done, (k == FBI - 1)); end
      @(negedge Clock);
    end
    exp_count = exp_count + 8'd1;
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (Sout_Valid !== 1'b0) begin n_err++; $display("FAIL busy_idle_valid%0d: got %b want 0", k, Sout_Valid); end
      n_vec++; if (Frame_Count !== exp_count) begin n_err++; $display("FAIL busy_count%0d: got %0d want %0d", k, Frame_Count, exp_count); end
      @(negedge Clock);
    end
  endtask

  task automatic test_clear_midframe(input logic [W-1:0] w, input logic [W-1:0] w2);
    logic [FB-1:0] f;
    f = frame_of(w);
    Pin = w; Load_Valid = 1'b1;
    @(negedge Clock);
    Load_Valid = 1'b0;
    n_vec++; if (Sout !== f[0]) begin n_err++; $display("FAIL clr_bit0: Sout=%b want %b", Sout, f[0]); end
    @(negedge Clock);
    n_vec++; if (Sout !== f[1]) begin n_err++; $display("FAIL clr_bit1: Sout=%b want %b", Sout, f[1]); end
    #2 Clear = 1'b1;
    #1;
    n_vec++; if (Sout !== IDLE) begin n_err++; $display("FAIL clr_async_sout: got %b want %b", Sout, IDLE); end
    n_vec++; if (Sout_Valid !== 1'b0) begin n_err++; $display("FAIL clr_async_valid: got %b want 0", Sout_Valid); end
    n_vec++; if (Frame_Count !== 8'd0) begin n_err++; $display("FAIL clr_async_count: got %0d want 0", Frame_Count); end
    n_vec++; if (Load_Ready !== 1'b0) begin n_err++; $display("FAIL clr_async_ready: got %b want 0", Load_Ready); end
    @(negedge Clock);
    Clear = 1'b0;
    exp_count = '0;
    test_single_frame(w2, "after_clear");
  endtask

  // 256 back-to-back frames from a cleared counter: passes through 255 and wraps to 0.
  task automatic test_count_wrap();
    int n_done;
    n_done = 0;
    Clear = 1'b1; #1; Clear = 1'b0;
    exp_count = '0;
    Pin = W'($urandom); Load_Valid = 1'b1;
    for (int c = 1; c <= 256 * FBI; c++) begin
      @(negedge Clock);
      if (Frame_Done === 1'b1) n_done++;
      if (c == 255 * FBI + 1) begin
        n_vec++; if (Frame_Count !== 8'd255) begin n_err++; $display("FAIL wrap_count255: got %0d want 255", Frame_Count); end
      end
      if (c == 256 * FBI) Load_Valid = 1'b0;
      n_vec++; if (Sout_Valid !== 1'b1) begin n_err++; $display("FAIL wrap_gap_c%0d: Sout_Valid=%b want 1", c, Sout_Valid); end
    end
    @(negedge Clock);
    n_vec++; if (n_done != 256) begin n_err++; $display("FAIL wrap_done_pulses: got %0d want 256", n_done); end
    n_vec++; if (Frame_Count !== 8'd0) begin n_err++; $display("FAIL wrap_count0: got %0d want 0", Frame_Count); end
    n_vec++; if (Sout_Valid !== 1'b0) begin n_err++; $display("FAIL wrap_idle_valid: got %b want 0", Sout_Valid); end
  endtask

  // Random traffic and clears checked against a queue of pending line bits.
  task automatic test_random(input int n);
    logic [1:0]    pend[$];
    logic [1:0]    e;
    logic          cur_v, cur_b, cur_l, hold, rdy;
    logic [7:0]    cnt_m;
    logic [FB-1:0] f;
    pend.delete();
    cur_v = 1'b0; cur_b = IDLE; cur_l = 1'b0; hold = 1'b0;
    cnt_m = exp_count;
    for (int c = 0; c < n; c++) begin
      rdy = !Clear && (pend.size() == 0);
      n_vec++; if (Sout_Valid !== cur_v) begin n_err++; $display("FAIL rnd_valid_c%0d: got %b want %b", c, Sout_Valid, cur_v); end
      n_vec++; if (Sout !== (cur_v ? cur_b : IDLE)) begin n_err++; $display("FAIL rnd_sout_c%0d: got %b want %b", c, Sout, (cur_v ? cur_b : IDLE)); end
      n_vec++; if (Frame_Done !== (cur_v && cur_l)) begin n_err++; $display("FAIL rnd_done_c%0d: got %b want %b", c, Frame_Done, (cur_v && cur_l)); end
      n_vec++; if (Frame_Count !== cnt_m) begin n_err++; $display("FAIL rnd_count_c%0d: got %0d want %0d", c, Frame_Count, cnt_m); end
      n_vec++; if (Load_Ready !== rdy) begin n_err++; $display("FAIL rnd_ready_c%0d: got %b want %b", c, Load_Ready, rdy); end

      if (Clear) Clear = 1'b0;
      else if ($urandom_range(0, 79) == 0) Clear = 1'b1;
      if (!hold) begin
        Load_Valid = ($urandom_range(0, 3) != 0);
        Pin        = W'($urandom);
      end

      if (Clear) begin
        pend.delete();
        cur_v = 1'b0; cur_l = 1'b0; cnt_m = '0; hold = 1'b0;
      end else begin
        if (cur_v && cur_l) cnt_m = cnt_m + 8'd1;
        if (Load_Valid && (pend.size() == 0)) begin
          f = frame_of(Pin);
          for (int i = 0; i < FBI; i++) pend.push_back({(i == FBI - 1), f[i]});
          hold = 1'b0;
        end else begin
          hold = Load_Valid;
        end
        if (pend.size() != 0) begin
          e = pend.pop_front();
          cur_v = 1'b1; cur_l = e[1]; cur_b = e[0];
        end else begin
          cur_v = 1'b0; cur_l = 1'b0;
        end
      end
      @(negedge Clock);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_count = '0;
    Clear = 1'b1; Load_Valid = 1'b0; Pin = '0;
    test_reset();
    test_single_frame(W'(4'b1011), "single_1011");
    test_single_frame(W'(4'b0110), "single_0110");
    test_back_to_back(W'(4'b1011), W'(4'b0110));
    test_sipo(W'(4'b1101));
    test_ignore_busy(W'(4'b1010), W'(4'b1111));
    test_clear_midframe(W'(4'b1011), W'(4'b0001));
    test_count_wrap();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out stage that sits directly upstream of the SIPO shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it onto the serial line one bit per Clock.
- Its Sout output connects straight to the SIPO's Sin.
- Supports back-to-back frames with no idle gap, so the SIPO sees a continuous bit stream.

Parameters:
- WIDTH, 4, word width in bits (2..32).
- LSB_FIRST, 0, 0 = MSB shifted first (matches the SIPO fill order), 1 = LSB first.
- IDLE_LEVEL, 0, value driven on Sout when no frame is active.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Clear  input  1  asynchronous, active-high reset.
- Pin  input  WIDTH  parallel word; sampled on the accept edge.
- Load_Valid  input  1  Pin holds a word to send.
- Load_Ready  output  1  block can accept a word this cycle.
- Sout  output  1  serial data; connects to the SIPO Sin.
- Sout_Valid  output  1  Sout carries a frame bit this cycle.
- Frame_Done  output  1  one-cycle pulse while the last bit of a frame is on Sout.
- Frame_Count  output  8  number of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (Clear=1, asynchronous):
  - Return to IDLE and zero the shift register and bit counter.
  - Sout=IDLE_LEVEL, Sout_Valid=0, Frame_Done=0, Frame_Count=0.
  - Load_Ready=0 while Clear is high.
- States: IDLE, SHIFT.
- Accept: an accept occurs on a rising edge where Load_Valid=1 and Load_Ready=1.
  - Pin is captured into the shift register and the bit counter is loaded with WIDTH-1.
- Load_Ready is combinational and equals (state==IDLE) or (state==SHIFT and bit counter==0), gated by !Clear.
- Latency:
  - The first bit appears on Sout (registered) in the cycle after the accept edge.
  - Bit WIDTH-1 comes first when LSB_FIRST=0; bit 0 comes first when LSB_FIRST=1.
  - One further bit follows per Clock, so WIDTH cycles per frame.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT stays in SHIFT while bit counter > 0; the counter decrements each cycle.
  - SHIFT, counter==0, with accept: stay in SHIFT and reload. The next frame's first bit follows the last bit with zero gap.
  - SHIFT, counter==0, no accept: go to IDLE. The next cycle drives Sout=IDLE_LEVEL and Sout_Valid=0.
- Sout_Valid=1 in exactly the cycles a frame bit is on Sout.
- Frame_Done=1 in the cycle the final frame bit is on Sout.
- Frame_Count increments by 1 on the edge that ends each completed frame.
- Load_Valid while Load_Ready=0 is ignored and Pin is not sampled. The upstream source holds Pin/Load_Valid until it sees Load_Ready.
- Changes on Pin after the accept edge do not affect the frame in flight.
- Clear mid-frame:
  - The frame is abandoned and the block goes to IDLE immediately.
  - Frame_Count does not count the partial frame.
  - After Clear deasserts, the first accept is possible on the next rising edge.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Each frame is WIDTH+1 bits: the data bits followed by one even-parity bit (XOR of all WIDTH captured bits).
  - Frame_Done and Load_Ready are asserted on the parity-bit cycle instead of the last data bit.
  - Back-to-back spacing becomes WIDTH+1 cycles.
- Undefined: no parity bit; frame is exactly WIDTH bits; no parity logic is synthesised.

Test Plan:
1. Reset, then Load_Valid=1, Pin=4'b1011 for one accept edge (WIDTH=4, LSB_FIRST=0).
   -> Sout = 1,0,1,1 on the next 4 cycles, Sout_Valid=1 for those 4 cycles.
   -> Frame_Done high on the 4th only; then Sout=0, Sout_Valid=0, Frame_Count=1.
2. Back-to-back: Load_Valid held high with Pin=4'b1011, then Pin=4'b0110 presented when Load_Ready rises during the last bit.
   -> 8 contiguous bits 1,0,1,1,0,1,1,0 with no gap; Frame_Count=2.
3. Serializer driving the SIPO's Sin, frame 4'b1101.
   -> SIPO Pout=4'b1101 at the edge after Frame_Done.
4. Assert Clear for one cycle after the 2nd bit of 4'b1011.
   -> Sout=0, Sout_Valid=0, Frame_Count=0 immediately, without waiting for Clock.
   -> A new accept of 4'b0001 then produces 0,0,0,1.
5. Pulse Load_Valid with Pin=4'b1111 while the 2nd bit of a 4'b1010 frame is on Sout.
   -> Word ignored; output stays 1,0,1,0 then idle; Frame_Count=1.
6. PISO_PARITY_EN defined, Pin=4'b1011.
   -> Sout = 1,0,1,1,1 (parity 1); Frame_Done on the 5th bit.
   -> Pin=4'b0110 gives 0,1,1,0,0.
